// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle controller.
// States, select codes, opcode/funct constants and the class bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  localparam logic [1:0] A3_RD = 2'd0;
  localparam logic [1:0] A3_RT = 2'd1;
  localparam logic [1:0] A3_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;

  typedef struct packed {
    logic jr;
    logic jal;
    logic lui;
    logic beq;
    logic sw;
    logic lw;
    logic ori;
    logic subu;
    logic addu;
  } cls_t;

endpackage

// File: rtl/mc_class_dec.sv
// mc_class_dec: opcode/funct to one-hot instruction class.
// valid_o is low for any encoding outside the supported set.
module mc_class_dec
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_t       cls_o,
  output logic       valid_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADDU:  cls_o.addu = 1'b1;
          F_SUBU:  cls_o.subu = 1'b1;
          F_JR:    cls_o.jr   = 1'b1;
          default: cls_o      = '0;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: cls_o     = '0;
    endcase
  end

  assign valid_o = |cls_o;

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the shared datapath.
// FSM, class register, memory timeout counter and control decode.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic [1:0] alu_op,
  output logic       alu_b_sel,
  output logic       ext_op,
  output logic       reg_we,
  output logic [1:0] a3_sel,
  output logic [1:0] wd_sel,
  output logic       illegal,
  output logic       mem_err
);

  state_t          state_q, state_d;
  cls_t            cls_q, cls_d;
  logic [TO_W-1:0] to_q, to_d;
  cls_t            dec_cls;
  logic            dec_valid;
  logic            waiting;
  logic            to_hit;

  mc_class_dec u_dec (
    .opcode_i (opcode),
    .funct_i  (funct),
    .cls_o    (dec_cls),
    .valid_o  (dec_valid)
  );

  assign waiting = ((state_q == S_IF) || (state_q == S_MEM))
                 && !mem_ready;
  assign to_hit  = (MEM_TIMEOUT > 0) && waiting
                 && (to_q == TO_W'(MEM_TIMEOUT - 1));

  // counter only runs while a request is pending; any exit clears it
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    to_d    = '0;
    if ((MEM_TIMEOUT > 0) && waiting && !to_hit)
      to_d = to_q + TO_W'(1);
    case (state_q)
      S_IF: begin
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        cls_d = dec_cls;
        if (!dec_valid || dec_cls.jal || dec_cls.jr)
          state_d = S_IF;
        else
          state_d = S_EX;
      end
      S_EX: begin
        if (cls_q.lw || cls_q.sw)
          state_d = S_MEM;
        else if (cls_q.beq || cls_q.jal || cls_q.jr)
          state_d = S_IF;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)
          state_d = cls_q.sw ? S_IF : S_WB;
        else if (to_hit)
          state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      cls_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      to_q    <= to_d;
    end
  end

  assign state = state_q;

  // reset masks every strobe; only the IF fetch request stays up
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = NPC_PC4;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    ext_op    = 1'b0;
    reg_we    = 1'b0;
    a3_sel    = A3_RD;
    wd_sel    = WD_ALU;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    if (state_q == S_IF) mem_req = 1'b1;
    if (reset_n) begin
      case (state_q)
        S_IF: begin
          ir_we   = mem_ready;
          pc_we   = mem_ready;
          mem_err = to_hit;
        end
        S_ID: begin
          if (!dec_valid) begin
            illegal = 1'b1;
          end else if (dec_cls.jal) begin
            reg_we  = 1'b1;
            a3_sel  = A3_RA;
            wd_sel  = WD_PC;
            pc_we   = 1'b1;
            npc_sel = NPC_J;
          end else if (dec_cls.jr) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JR;
          end
        end
        S_EX: begin
          unique case (1'b1)
            cls_q.beq: begin
              alu_op = ALU_SUB;
              if (zero) begin
                pc_we   = 1'b1;
                npc_sel = NPC_BR;
              end
            end
            cls_q.lw, cls_q.sw: begin
              alu_op    = ALU_ADD;
              alu_b_sel = 1'b1;
              ext_op    = 1'b1;
            end
            cls_q.subu: alu_op = ALU_SUB;
            cls_q.ori: begin
              alu_op    = ALU_OR;
              alu_b_sel = 1'b1;
            end
            cls_q.lui: begin
              alu_op    = ALU_LUI;
              alu_b_sel = 1'b1;
            end
            default: alu_op = ALU_ADD;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = cls_q.sw;
          mem_err  = to_hit;
        end
        S_WB: begin
          reg_we = 1'b1;
          a3_sel = (cls_q.lw || cls_q.ori || cls_q.lui) ? A3_RT : A3_RD;
          wd_sel = cls_q.lw ? WD_MEM : WD_ALU;
        end
        default: mem_req = 1'b0;
      endcase
    end
  end

endmodule
